// File: rtl/reg_bank_ctrl_if.sv
// reg_bank_ctrl_if: controller-side bus of the register bank.
// Carries write/read requests and the backpressured read response.
interface reg_bank_ctrl_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
);
  logic              WrEn;
  logic              RdEn;
  logic [ADDR_W-1:0] Address;
  logic [WIDTH-1:0]  WrData;
  logic              RdReady;
  logic [WIDTH-1:0]  RdData;
  logic              RdData_Valid;
  logic              Err;

  modport master (
    output WrEn, RdEn, Address, WrData, RdReady,
    input  RdData, RdData_Valid, Err
  );

  modport slave (
    input  WrEn, RdEn, Address, WrData, RdReady,
    output RdData, RdData_Valid, Err
  );
endinterface

// File: rtl/reg_bank_ctrl.sv
// reg_bank_ctrl: config/status register bank with read handshake.
// Optional write lock on register DEPTH-1: macro REGBANK_WR_LOCK_EN.
module reg_bank_ctrl #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int NUM_EXPORT = 4,
  parameter logic [WIDTH*NUM_EXPORT-1:0] RST_VAL =
    {8'hA0, 8'h81, 8'h00, 8'h00},
  parameter logic [DEPTH-1:0] RO_MASK = '0,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                        clk,
  input  logic                        RST,
  reg_bank_ctrl_if.slave              bus,
  input  logic [WIDTH*DEPTH-1:0]      Status_In,
  output logic [WIDTH*NUM_EXPORT-1:0] REGS
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] hit;
  logic [DEPTH-1:0] we;
  logic             addr_ok;
  logic             ro_hit;
  logic             wr_ok;
  logic             wr_err;
  logic             rd_go;
  logic             rd_err;
  logic [WIDTH-1:0] rd_val;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;
  logic             err_q;
  logic             key_hit;
  logic             key_go;
  logic             lock_hit;
  logic [WIDTH-1:0] key_val;

  function automatic logic [WIDTH-1:0] rst_of(int i);
    logic [WIDTH*DEPTH-1:0] full;
    full = '0;
    full[WIDTH*NUM_EXPORT-1:0] = RST_VAL;
    return full[i*WIDTH +: WIDTH];
  endfunction

  // one-hot address decode; all zero when Address >= DEPTH
  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit[i] = (int'(bus.Address) == i);
    end
  end

  assign addr_ok = |hit;
  assign ro_hit  = |(hit & RO_MASK);

`ifdef REGBANK_WR_LOCK_EN
  logic lock_q;
  logic key_ok;

  assign key_hit  = hit[DEPTH-1];
  assign key_ok   = (bus.WrData[7:0] == 8'hA5);
  assign key_go   = bus.WrEn && key_hit && key_ok;
  assign lock_hit = lock_q && !key_hit
                  && |hit[NUM_EXPORT-1:0];
  assign key_val  = {{(WIDTH-1){1'b0}}, lock_q};

  // a correct key write flips the lock
  always_ff @(posedge clk) begin
    if (!RST) begin
      lock_q <= 1'b0;
    end else if (key_go) begin
      lock_q <= !lock_q;
    end
  end
`else
  assign key_hit  = 1'b0;
  assign key_go   = 1'b0;
  assign lock_hit = 1'b0;
  assign key_val  = '0;
`endif

  assign wr_ok  = bus.WrEn && addr_ok && !ro_hit
                && !key_hit && !lock_hit;
  assign we     = wr_ok ? hit : '0;
  assign wr_err = bus.WrEn && !wr_ok && !key_go;

  assign rd_go  = bus.RdEn && (!rd_valid_q || bus.RdReady);
  assign rd_err = rd_go && !addr_ok;

  // read mux sees pre-write contents; out of range reads 0
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (hit[i]) begin
        rd_val = rd_val | mem[i];
      end
    end
    if (key_hit) begin
      rd_val = key_val;
    end
  end

  // status registers track hardware, others take accepted writes
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!RST) begin
        mem[i] <= rst_of(i);
      end else if (RO_MASK[i]) begin
        mem[i] <= Status_In[i*WIDTH +: WIDTH];
      end else if (we[i]) begin
        mem[i] <= bus.WrData;
      end
    end
  end

  // read response register held until the consumer takes it
  always_ff @(posedge clk) begin
    if (!RST) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= wr_err || rd_err;
      if (rd_go) begin
        rd_data_q  <= rd_val;
        rd_valid_q <= 1'b1;
      end else if (rd_valid_q && bus.RdReady) begin
        rd_valid_q <= 1'b0;
      end
    end
  end

  assign bus.RdData       = rd_data_q;
  assign bus.RdData_Valid = rd_valid_q;
  assign bus.Err          = err_q;

  for (genvar g = 0; g < NUM_EXPORT; g++) begin : g_exp
    assign REGS[g*WIDTH +: WIDTH] = mem[g];
  end

endmodule

// File: doc/reg_bank_ctrl.md
# reg_bank_ctrl

Parametrised configuration/status register bank for the system control path. It replaces the fixed 8x16 register file with:
- configurable width, depth, exported-register count and per-register reset values;
- read-only status registers fed by hardware;
- a backpressured read-response handshake;
- defined simultaneous read/write behaviour;
- error reporting.

It sits between the system controller FSM and the UART/clock-divider configuration consumers.

## Interface
Parameters:
- WIDTH, 8, data width of every register.
- DEPTH, 16, number of registers; need not be a power of two.
- NUM_EXPORT, 4, registers 0..NUM_EXPORT-1 driven continuously on REGS; range 1..DEPTH.
- RST_VAL, {8'hA0, 8'h81, 8'h00, 8'h00}, flat WIDTH*NUM_EXPORT reset values; slice i belongs to register i. Registers >= NUM_EXPORT reset to 0.
- RO_MASK, 0, DEPTH-bit mask; bit i set = register i is read-only status.

Ports:
- clk  in  1  system clock, rising edge.
- RST  in  1  reset; synchronous, active-low.
- WrEn  in  1  write request.
- RdEn  in  1  read request.
- Address  in  ADDR_W=$clog2(DEPTH)  register index.
- WrData  in  WIDTH  write data.
- Status_In  in  WIDTH*DEPTH  hardware status values, sampled only for RO registers.
- RdReady  in  1  consumer accepts RdData this cycle.
- RdData  out  WIDTH  read response data.
- RdData_Valid  out  1  RdData valid; held until RdReady.
- Err  out  1  one-cycle error pulse.
- REGS  out  WIDTH*NUM_EXPORT  live contents of registers 0..NUM_EXPORT-1.

## Operation
Reset:
- Applies while RST=0 at a clk edge.
- Registers take RST_VAL, or 0 for registers >= NUM_EXPORT.
- RdData=0, RdData_Valid=0, Err=0. Lock state (see Configuration) = unlocked.
- A reset during a pending read drops the response.

Status registers:
- Every cycle, each register with RO_MASK[i]=1 loads Status_In slice i.

Write (WrEn=1):
- Accepted only when Address < DEPTH and RO_MASK[Address]=0.
- The register updates at the edge.
- Otherwise no register changes and Err=1 on the next cycle.

Read handshake:
- The read port can accept a read when RdData_Valid=0, or when RdData_Valid=1 and RdReady=1.
- A read issued when the port can accept: RdData is loaded and RdData_Valid=1 at the next edge.
- A read issued when the port cannot accept is ignored (no response, no Err). The requester must hold RdEn.
- Address >= DEPTH: RdData=0, RdData_Valid=1, Err=1.
- While RdData_Valid=1 and RdReady=0, RdData and RdData_Valid hold stable.
- When RdData_Valid=1, RdReady=1 and no new read is issued, RdData_Valid clears. RdData holds its last value.

Simultaneous WrEn and RdEn:
- Both execute in the same cycle.
- Read-before-write: the read returns the pre-write contents, including at the same address.
- Err is the OR of both error sources.

Err:
- A single-cycle pulse, registered, one cycle after the offending request.

## Timing
- Write to REGS visibility: 1 cycle.
- Read latency: 1 cycle from accepted RdEn to RdData_Valid=1.
- Back-to-back reads with RdReady tied to 1: one response per cycle, RdData_Valid stays high.
- Status_In to readable value: 1 cycle.
- REGS is purely registered; no combinational path from inputs.

## Configuration
Macro REGBANK_WR_LOCK_EN.

When defined:
- Register DEPTH-1 acts as a lock key port and is never stored.
- Writing 8'hA5 (low 8 bits) to it toggles the lock state.
- Writing any other value to it sets Err.
- Reads of DEPTH-1 return {WIDTH-1 zeros, lock}.
- While locked, writes to addresses < NUM_EXPORT are rejected with Err.

When undefined:
- Register DEPTH-1 is an ordinary register.
- No lock logic is present.

## Test plan
- Reset, then read 2 and 3 with RdReady=1 -> RdData 8'h81 then 8'hA0, each 1 cycle after RdEn. REGS = 32'hA0810000.
- Write 8'h5C to 1, then read 1 -> REGS[15:8]=8'h5C the cycle after the write; RdData=8'h5C, RdData_Valid=1.
- RdEn(addr 5) with RdReady=0 for 3 cycles, then RdReady=1 -> RdData and RdData_Valid held for 3 cycles; a second RdEn during the stall produces no response; RdData_Valid drops after acceptance.
- Reg 4 holds 8'h11; WrEn and RdEn both to 4 with WrData=8'h22 -> RdData=8'h11, a subsequent read returns 8'h22.
- RO_MASK bit 6 set, Status_In slice 6=8'h3C; write 8'hFF to 6 -> Err pulses 1 cycle, read returns 8'h3C. DEPTH=12: read addr 13 -> RdData=0, Err=1.
- REGBANK_WR_LOCK_EN defined, DEPTH=16: write 8'hA5 to 15, then write 8'h77 to 0 -> Err=1, REGS[7:0] unchanged; write 8'hA5 to 15 again, rewrite 8'h77 to 0 -> accepted.
